flux_tag_arbiter: RTL and testbench

- Upstream feeder for the shared-buffer multi-flux FIFO.
- Accepts FLUX independent valid/ready input streams and buffers each in a 2-entry skid FIFO.
- Arbitrates round-robin among non-empty channels, prepends the channel index as a binary tag in the MSBs, and drives the FIFO write port under its global full.
- Optionally caps per-flux occupancy inside the shared FIFO so one flux cannot starve the others.

---
 rtl/flux_tag_arbiter.sv | 136 +++++++++++++
 tb/tb_flux_tag_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/flux_tag_arbiter.sv
// flux_tag_arbiter: per-channel 2-entry skid buffers feeding a round-robin
// arbiter that tags each word with its source channel and writes it into a
// shared downstream FIFO.
// Optional feature macro: FLUX_QUOTA_EN caps per-flux residency downstream.

module flux_skid #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            count
);
  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];
endmodule

module flux_tag_arbiter #(
  parameter  int DATA_WIDTH = 8,
  parameter  int FLUX       = 2,
  parameter  int DEPTH      = 4,
  parameter  int QUOTA      = 2,
  localparam int TAG_WIDTH  = $clog2(FLUX),
  localparam int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FLUX-1:0]            in_valid,
  input  logic [FLUX*DATA_WIDTH-1:0] in_data,
  output logic [FLUX-1:0]            in_ready,
  input  logic                       fifo_full,
  output logic                       fifo_write,
  output logic [WIDTH-1:0]           fifo_din,
  input  logic [FLUX-1:0]            fifo_read
);
  logic [FLUX-1:0][DATA_WIDTH-1:0] head;
  logic [FLUX-1:0][1:0]            count;
  logic [FLUX-1:0]                 elig;
  logic [FLUX-1:0]                 quota_ok;
  logic [FLUX-1:0]                 pop;
  logic [TAG_WIDTH-1:0]            rr_ptr;
  logic [TAG_WIDTH-1:0]            gnt_idx;
  logic                            found;

  for (genvar c = 0; c < FLUX; c++) begin : g_lane
    assign in_ready[c] = !rst && (count[c] != 2'd2);
    assign elig[c]     = (count[c] != 2'd0) && quota_ok[c];
    assign pop[c]      = fifo_write && (gnt_idx == TAG_WIDTH'(c));

    flux_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid[c] && in_ready[c]),
      .pop   (pop[c]),
      .din   (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .dout  (head[c]),
      .count (count[c])
    );
  end

  // First eligible channel scanning upward from rr_ptr, wrapping at FLUX.
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < FLUX; i++) begin
      int s;
      s = int'(rr_ptr) + i;
      if (s >= FLUX) s = s - FLUX;
      if (!found && elig[TAG_WIDTH'(s)]) begin
        found   = 1'b1;
        gnt_idx = TAG_WIDTH'(s);
      end
    end
  end

  // Write side depends only on registered state, fifo_full and rst.
  assign fifo_write = !rst && !fifo_full && found;
  assign fifo_din   = fifo_write ? {gnt_idx, head[gnt_idx]} : '0;

  // Round-robin pointer moves past the granted channel only on a write.
  always_ff @(posedge clk) begin
    if (rst)             rr_ptr <= '0;
    else if (fifo_write) rr_ptr <= (gnt_idx == TAG_WIDTH'(FLUX-1)) ? '0 : gnt_idx + 1'b1;
  end

`ifdef FLUX_QUOTA_EN
  localparam int OCC_W = $clog2(DEPTH) + 1;
  logic [FLUX-1:0][OCC_W-1:0] occ;

  for (genvar c = 0; c < FLUX; c++) begin : g_quota
    // Words of flux c resident downstream; a same-cycle read does not
    // free the slot for this cycle's grant since quota_ok uses registered occ.
    always_ff @(posedge clk) begin
      if (rst)
        occ[c] <= '0;
      else if (pop[c] && !fifo_read[c] && occ[c] < OCC_W'(QUOTA))
        occ[c] <= occ[c] + 1'b1;
      else if (!pop[c] && fifo_read[c] && occ[c] != '0)
        occ[c] <= occ[c] - 1'b1;
    end
    assign quota_ok[c] = occ[c] < OCC_W'(QUOTA);
  end
`else
  logic unused_read;
  assign quota_ok    = '1;
  assign unused_read = ^{fifo_read, DEPTH[0], QUOTA[0]};
`endif
endmodule

// File: tb/tb_flux_tag_arbiter.sv
// Directed bench for flux_tag_arbiter (FLUX=2, DATA_WIDTH=8) with an
// expected-write queue checked whenever the DUT writes.
module tb_flux_tag_arbiter;
  localparam int DW = 8;
  localparam int FX = 2;
  localparam int W  = DW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [FX-1:0] in_valid;
  logic [FX*DW-1:0] in_data;
  logic [FX-1:0] in_ready;
  logic          fifo_full;
  logic          fifo_write;
  logic [W-1:0]  fifo_din;
  logic [FX-1:0] fifo_read;
  logic [FX-1:0] rd_auto = '0;
  logic [FX-1:0] rd_man;
  logic          auto_rd;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;

  always #5 clk = ~clk;

  assign fifo_read = auto_rd ? rd_auto : rd_man;

  flux_tag_arbiter #(.DATA_WIDTH(DW), .FLUX(FX), .DEPTH(4), .QUOTA(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .fifo_full(fifo_full), .fifo_write(fifo_write),
    .fifo_din(fifo_din), .fifo_read(fifo_read)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Downstream that pops each word right after it lands.
  always @(negedge clk) rd_auto <= fifo_write ? (FX'(1) << fifo_din[W-1]) : '0;

  // Scoreboard: every write must match the oldest expected word.
  always @(negedge clk) begin
    if (fifo_write) begin
      chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_data", 32'(fifo_din), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FX-1:0] acc;
    int s0, s1, guard;
    logic [5:0] wr_obs;
    logic [5:0] wr_exp;

    // Reset held with valid inputs: nothing accepted, nothing written.
    rst = 1'b1; in_valid = 2'b11; in_data = 16'h1234; fifo_full = 1'b0;
    rd_man = '0; auto_rd = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_write", 32'(fifo_write), 32'd0);
      chk("rst_din", 32'(fifo_din), 32'd0);
    end
    cyc();
    rst = 1'b0; in_valid = 2'b00;
    @(negedge clk);
    chk("rel_ready", 32'(in_ready), 32'h3);

    // Tagging and one-cycle latency.
    cyc();
    in_valid = 2'b01; in_data = {8'h00, 8'hA5}; exp_q.push_back(9'h0A5);
    cyc();
    in_valid = 2'b00;
    @(negedge clk);
    chk("lat_ch0", 32'(fifo_write), 32'd1);
    cyc();
    in_valid = 2'b10; in_data = {8'h3C, 8'h00}; exp_q.push_back(9'h13C);
    cyc();
    in_valid = 2'b00;
    @(negedge clk);
    chk("lat_ch1", 32'(fifo_write), 32'd1);
    repeat (3) cyc();

    // Round-robin streaming on both channels.
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({1'b0, 8'(i)});
      exp_q.push_back({1'b1, 8'(i)});
    end
    s0 = 0; s1 = 0; guard = 0;
    while ((s0 < 6 || s1 < 6) && guard < 100) begin
      in_valid = {s1 < 6, s0 < 6};
      in_data  = {8'(s1), 8'(s0)};
      acc = in_valid & in_ready;
      cyc();
      s0 += int'(acc[0]); s1 += int'(acc[1]);
      guard++;
    end
    chk("rr_sent", 32'(s0 + s1), 32'd12);
    in_valid = 2'b00;
    repeat (8) cyc();
    chk("rr_drained", 32'(exp_q.size()), 32'd0);

    // Back-pressure: buffers fill, then drain alternately in order.
    fifo_full = 1'b1; s0 = 0; s1 = 0;
    for (int j = 0; j < 6; j++) begin
      in_valid = 2'b11;
      in_data  = {8'(8'h50 + s1), 8'(8'h40 + s0)};
      acc = in_valid & in_ready;
      @(negedge clk);
      chk("bp_write", 32'(fifo_write), 32'd0);
      if (j >= 2) chk("bp_ready", 32'(in_ready), 32'd0);
      cyc();
      s0 += int'(acc[0]); s1 += int'(acc[1]);
    end
    fifo_full = 1'b0; in_valid = 2'b00;
    exp_q.push_back(9'h040); exp_q.push_back(9'h150);
    exp_q.push_back(9'h041); exp_q.push_back(9'h151);
    @(negedge clk);
    chk("bp_release", 32'(fifo_write), 32'd1);
    repeat (6) cyc();
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Four words on ch0 alone; with the quota only two may go out.
    auto_rd = 1'b0; rd_man = '0;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'(8'h60 + i)});
    for (int j = 0; j < 6; j++) begin
      in_valid = {1'b0, j < 4};
      in_data  = {8'h00, 8'(8'h60 + j)};
      @(negedge clk);
      wr_obs[j] = fifo_write;
      cyc();
    end
    in_valid = 2'b00;
`ifdef FLUX_QUOTA_EN
    wr_exp = 6'b000110;
    chk("quota_pattern", 32'(wr_obs), 32'(wr_exp));
    rd_man = 2'b01;
    @(negedge clk);
    chk("quota_read_cyc", 32'(fifo_write), 32'd0);
    cyc();
    rd_man = 2'b00;
    @(negedge clk);
    chk("quota_one_more", 32'(fifo_write), 32'd1);
    cyc();
    @(negedge clk);
    chk("quota_stall", 32'(fifo_write), 32'd0);
    cyc();
    rd_man = 2'b01;
    repeat (3) cyc();
    rd_man = 2'b00;
`else
    wr_exp = 6'b011110;
    chk("b2b_pattern", 32'(wr_obs), 32'(wr_exp));
`endif
    auto_rd = 1'b1;
    repeat (3) cyc();
    chk("quota_drained", 32'(exp_q.size()), 32'd0);

    // Mid-operation reset drops buffered words.
    fifo_full = 1'b1; in_valid = 2'b11; in_data = 16'h7777;
    repeat (2) cyc();
    rst = 1'b1; in_valid = 2'b00;
    @(negedge clk);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    cyc();
    rst = 1'b0; fifo_full = 1'b0;
    @(negedge clk);
    chk("mid_rel_ready", 32'(in_ready), 32'h3);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("mid_no_stale", 32'(fifo_write), 32'd0);
    end
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
